// File: rtl/jesd207_fifo_pkg.sv
// jesd207_fifo_pkg: shared constants and FULL threshold helper for the JESD207 FIFO controller.
package jesd207_fifo_pkg;
  localparam int AW_DEF = 7;
  localparam int PW_DEF = AW_DEF + 1;
  function automatic int full_thr(input int aw);
    return (1 << aw) - 2;
  endfunction
endpackage

// File: rtl/jesd207_fifo_ptr.sv
// jesd207_fifo_ptr: pointer register with fixed increment step and synchronous clear.
module jesd207_fifo_ptr #(
  parameter int W    = 8,
  parameter int STEP = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);
  logic [W-1:0] ptr_q, ptr_d;
  always_comb ptr_d = clr_i ? '0 : inc_i ? ptr_q + W'(STEP) : ptr_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) ptr_q <= '0;
    else ptr_q <= ptr_d;
  assign ptr_o = ptr_q;
endmodule

// File: rtl/jesd207_fifo_ctrl.sv
// jesd207_fifo_ctrl: enable/address sequencing, occupancy flags and output stage for the JESD207 FIFO RAM.
// Defining JESD207_FIFO_ERR_EN adds sticky overflow/underflow flags with ERR_CLR.
module jesd207_fifo_ctrl import jesd207_fifo_pkg::*; #(
  parameter int AW = AW_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          FLUSH,
  input  logic          IN_VALID,
  output logic          IN_READY,
  output logic          WR_EN,
  output logic [AW-1:0] ADDR_WR,
  output logic          RD_EN,
  output logic [AW-1:0] ADDR_RD,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [AW:0]   LEVEL,
  output logic          EMPTY,
`ifdef JESD207_FIFO_ERR_EN
  input  logic          ERR_CLR,
  output logic          OVF_ERR,
  output logic          UDF_ERR,
`endif
  output logic          FULL
);
  localparam int PW = AW + 1;
  localparam logic [AW:0] FULL_THR = PW'(full_thr(AW));
  logic [AW:0] wptr, rptr;
  logic out_valid_q, out_valid_d;
  jesd207_fifo_ptr #(.W(PW), .STEP(2)) u_wptr (
    .clk_i(CLK), .rst_i(RST), .clr_i(FLUSH), .inc_i(WR_EN), .ptr_o(wptr)
  );
  jesd207_fifo_ptr #(.W(PW), .STEP(1)) u_rptr (
    .clk_i(CLK), .rst_i(RST), .clr_i(FLUSH), .inc_i(RD_EN), .ptr_o(rptr)
  );
  assign LEVEL     = wptr - rptr;
  assign EMPTY     = LEVEL == '0;
  assign FULL      = LEVEL > FULL_THR;
  assign IN_READY  = !FULL && !FLUSH;
  assign WR_EN     = IN_VALID && IN_READY;
  assign ADDR_WR   = wptr[AW-1:0];
  assign ADDR_RD   = rptr[AW-1:0];
  assign OUT_VALID = out_valid_q;
  // Prefetch into the one-entry output stage whenever it is empty or being drained.
  assign RD_EN     = !EMPTY && !FLUSH && (!out_valid_q || OUT_READY);
  always_comb out_valid_d = !FLUSH && (RD_EN || (out_valid_q && !OUT_READY));
  always_ff @(posedge CLK or posedge RST)
    if (RST) out_valid_q <= 1'b0;
    else out_valid_q <= out_valid_d;
`ifdef JESD207_FIFO_ERR_EN
  logic primed_q, primed_d, ovf_q, ovf_d, udf_q, udf_d;
  always_comb begin
    primed_d = !FLUSH && (primed_q || WR_EN);
    ovf_d    = !ERR_CLR && (ovf_q || (IN_VALID && !IN_READY && !FLUSH));
    udf_d    = !ERR_CLR && (udf_q || (OUT_READY && !out_valid_q && primed_q));
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      primed_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      primed_q <= primed_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  assign OVF_ERR = ovf_q;
  assign UDF_ERR = udf_q;
`endif
endmodule

// File: tb/tb_jesd207_fifo_ctrl.sv
// tb_jesd207_fifo_ctrl: directed bench with a RAM model and in-order data scoreboard, AW = 3.
module tb_jesd207_fifo_ctrl;
  localparam int AW = 3;
  logic CLK = 1'b0, RST = 1'b1, FLUSH = 1'b0, IN_VALID = 1'b0, OUT_READY = 1'b0;
  logic IN_READY, WR_EN, RD_EN, OUT_VALID, EMPTY, FULL;
  logic [AW-1:0] ADDR_WR, ADDR_RD;
  logic [AW:0] LEVEL;
`ifdef JESD207_FIFO_ERR_EN
  logic ERR_CLR = 1'b0, OVF_ERR, UDF_ERR;
`endif
  int n_cmp = 0, n_err = 0;
  int e_w = 0, e_r = 0;
  logic [7:0] mem [8];
  logic [7:0] q = '0;

  jesd207_fifo_ctrl #(.AW(AW)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .WR_EN(WR_EN), .ADDR_WR(ADDR_WR), .RD_EN(RD_EN), .ADDR_RD(ADDR_RD),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .LEVEL(LEVEL), .EMPTY(EMPTY),
`ifdef JESD207_FIFO_ERR_EN
    .ERR_CLR(ERR_CLR), .OVF_ERR(OVF_ERR), .UDF_ERR(UDF_ERR),
`endif
    .FULL(FULL)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // RAM and producer/consumer model, evaluated mid-cycle when the handshake inputs are stable.
  always @(negedge CLK) begin
    if (RST) begin
      e_w <= 0;
      e_r <= 0;
    end else begin
      if (OUT_VALID && OUT_READY) begin
        chk("sb_data", {24'd0, q}, {24'd0, e_r[7:0]});
        e_r <= e_r + 1;
      end
      if (FLUSH) e_r <= e_w;
      if (WR_EN) begin
        mem[ADDR_WR]        <= e_w[7:0];
        mem[ADDR_WR + 3'd1] <= 8'(e_w + 1);
        e_w <= e_w + 2;
      end
      if (RD_EN) q <= mem[ADDR_RD];
    end
  end

  logic [AW-1:0] exp_aw [4] = '{3'd2, 3'd4, 3'd6, 3'd0};
  logic [AW:0]   exp_lv [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd6};
  logic          exp_ir [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    int base;
    logic [7:0] hold;
    #12;
    chk("rst_level", LEVEL, 0);
    chk("rst_empty", EMPTY, 1);
    chk("rst_full", FULL, 0);
    chk("rst_in_ready", IN_READY, 1);
    chk("rst_wr_en", WR_EN, 0);
    chk("rst_rd_en", RD_EN, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    tick();
    RST = 1'b0;
    // single pair: latency and LEVEL 0->2->1->0
    IN_VALID = 1'b1;
    #1;
    chk("p1_wr_en", WR_EN, 1);
    chk("p1_addr_wr", ADDR_WR, 0);
    chk("p1_rd_en", RD_EN, 0);
    tick();
    IN_VALID = 1'b0;
    #1;
    chk("p1_level2", LEVEL, 2);
    chk("p1_empty", EMPTY, 0);
    chk("p1_rd_en1", RD_EN, 1);
    chk("p1_addr_rd0", ADDR_RD, 0);
    tick();
    chk("p1_out_valid", OUT_VALID, 1);
    chk("p1_q0", q, 0);
    chk("p1_level1", LEVEL, 1);
    chk("p1_rd_stall", RD_EN, 0);
    OUT_READY = 1'b1;
    #1;
    chk("p1_rd_en2", RD_EN, 1);
    chk("p1_addr_rd1", ADDR_RD, 1);
    tick();
    chk("p1_q1", q, 1);
    chk("p1_level0", LEVEL, 0);
    chk("p1_empty0", EMPTY, 1);
    tick();
    chk("p1_drained", OUT_VALID, 0);
    OUT_READY = 1'b0;
    // fill to FULL with the consumer stalled; write address wraps 6->0
    for (int i = 0; i < 4; i++) begin
      IN_VALID = 1'b1;
      #1;
      chk("fill_wr_en", WR_EN, 1);
      chk("fill_addr_wr", ADDR_WR, exp_aw[i]);
      tick();
    end
    chk("fill_level", LEVEL, 7);
    chk("fill_full", FULL, 1);
    chk("fill_in_ready", IN_READY, 0);
    chk("fill_wr_blocked", WR_EN, 0);
    chk("fill_q", q, 2);
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    tick();
    tick();
    OUT_READY = 1'b0;
    #1;
    chk("pre_flush_level", LEVEL, 5);
    chk("pre_flush_valid", OUT_VALID, 1);
    chk("pre_flush_q", q, 4);
    // flush beats a concurrent write
    FLUSH = 1'b1;
    IN_VALID = 1'b1;
    #1;
    chk("flush_wr_en", WR_EN, 0);
    chk("flush_rd_en", RD_EN, 0);
    chk("flush_in_ready", IN_READY, 0);
    tick();
    FLUSH = 1'b0;
    IN_VALID = 1'b0;
    #1;
    chk("flush_level", LEVEL, 0);
    chk("flush_empty", EMPTY, 1);
    chk("flush_valid", OUT_VALID, 0);
    chk("flush_addr_wr", ADDR_WR, 0);
    chk("flush_addr_rd", ADDR_RD, 0);
    // continuous streaming, 256+ entries through several wraps
    base = e_r;
    IN_VALID = 1'b1;
    OUT_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("stream_level", LEVEL, exp_lv[i]);
      chk("stream_in_ready", IN_READY, exp_ir[i]);
      tick();
    end
    for (int c = 0; c < 1000 && (e_r - base) < 256; c++) tick();
    chk("stream_count", (e_r - base) >= 256, 1);
    IN_VALID = 1'b0;
    for (int c = 0; c < 20 && !(EMPTY && !OUT_VALID); c++) tick();
    chk("stream_drained", EMPTY && !OUT_VALID, 1);
    chk("stream_no_loss", e_r, e_w);
    // stalls keep Q stable and suppress reads
    OUT_READY = 1'b0;
    IN_VALID = 1'b1;
    tick();
    tick();
    IN_VALID = 1'b0;
    for (int i = 0; i < 10; i++) begin
      OUT_READY = i[0];
      #1;
      if (OUT_VALID && !OUT_READY) begin
        chk("stall_rd_en", RD_EN, 0);
        hold = q;
        tick();
        chk("stall_q_stable", q, hold);
      end else tick();
    end
    OUT_READY = 1'b1;
    for (int c = 0; c < 10 && !(EMPTY && !OUT_VALID); c++) tick();
    chk("stall_drained", EMPTY && !OUT_VALID, 1);
    chk("stall_no_loss", e_r, e_w);
`ifdef JESD207_FIFO_ERR_EN
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    #1;
    chk("err_cleared_u", UDF_ERR, 0);
    tick();
    chk("udf_set", UDF_ERR, 1);
    OUT_READY = 1'b0;
    IN_VALID = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("ovf_full", FULL, 1);
    chk("ovf_pre", OVF_ERR, 0);
    tick();
    chk("ovf_set", OVF_ERR, 1);
    IN_VALID = 1'b0;
    tick();
    chk("ovf_held", OVF_ERR, 1);
    IN_VALID = 1'b1;
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    IN_VALID = 1'b0;
    #1;
    chk("clr_ovf", OVF_ERR, 0);
    chk("clr_udf", UDF_ERR, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
